dcache_axi_bridge: RTL and testbench
====================================

// Module: dcache_axi_bridge
// PURPOSE
// Memory-side responder for the L1 data cache D-port (D_req_read/D_addr/D_in/D_strb in, D_out/D_wait out) inside the CPU wrapper.
// Converts cache-line fills, uncached word reads and word writes into AXI4 master transactions (ARSIZE=3'b010, INCR, no IDs; interconnect adds IDs).
// Returns read data one word per beat with the D_wait-low-per-beat protocol that the cache counts.
// PARAMETERS
// UNCACHE_HI  16'h1000  D_addr[31:16] value marking the uncached region (single-beat read, ARLEN=0)
// LINE_BEATS  4         words per line fill (ARLEN=LINE_BEATS-1); power of two, 2..16
// PORTS
// clk         in   1   clock
// rstn        in   1   asynchronous reset, active-low
// D_req_read  in   1   read request, held high until completion
// D_addr      in   32  request address (line-aligned for fills, word-aligned for writes)
// D_in        in   32  write data
// D_strb      in   4   active-low byte write enables; != 4'hF means write request
// D_out       out  32  read beat data, valid while D_wait=0
// D_wait      out  1   low for exactly one cycle per delivered beat or write completion
// D_err       out  1   one-cycle pulse with the final D_wait-low when any RRESP/BRESP != OKAY
// ARADDR      out  32  read address
// ARLEN       out  4   LINE_BEATS-1 for fill, 0 for uncached
// ARVALID     out  1   read address valid
// ARREADY     in   1   read address ready
// RDATA       in   32  read data
// RRESP       in   2   read response
// RVALID      in   1   read data valid
// RREADY      out  1   read data ready
// AWADDR      out  32  write address, {D_addr[31:2],2'b00}
// AWVALID     out  1   write address valid
// AWREADY     in   1   write address ready
// WDATA       out  32  write data (single beat; WLAST tied high at wrapper)
// WSTRB       out  4   ~D_strb
// WVALID      out  1   write data valid
// WREADY      in   1   write data ready
// BRESP       in   2   write response
// BVALID      in   1   write response valid
// BREADY      out  1   write response ready
// BEHAVIOUR
// - Reset (async): state IDLE, D_wait=1, D_out=0, D_err=0, all VALID/READY=0, beat counter=0.
// - FSM: IDLE -> AR (D_req_read) | AWW (D_strb!=4'hF; write has priority if both) ; AR -> R on ARREADY ; R -> DONE on last counted beat.
// - AWW: AWVALID/WVALID raised together, each dropped independently on its handshake; -> B when both done ; B (BREADY=1) -> DONE on BVALID.
// - Address/ARLEN/WDATA/WSTRB captured in IDLE at acceptance and held stable while VALID is high (AXI stability rule).
// - R: RREADY=1; each RVALID handshake registers RDATA into D_out and drives D_wait=0 the next cycle; back-to-back beats give consecutive D_wait-low cycles.
// - Beat counter counts R handshakes; last beat = count LINE_BEATS-1 (fill) or 0 (uncached); RLAST ignored, counter wraps to 0 on DONE.
// - B handshake drives D_wait=0 for one cycle (the DONE cycle); D_out unchanged on writes.
// - DONE lasts exactly one cycle and ignores requests: the cache still presents the old request that cycle; new requests accepted only from IDLE.
// - Latency: uncached read with ARREADY/RVALID immediate = AR cycle, R cycle, D_wait low in DONE (3 cycles from request); write = AWW, B, DONE.
// - Errors: non-OKAY response still completes normally (data passed through); D_err sticky within the transaction, pulsed on the final D_wait-low cycle.
// - rstn assertion mid-transaction abandons it (system-wide reset); no drain.
// STRUCTURE
// Package dcache_bus_pkg: state enum, AXI_BURST_INCR/AXI_SIZE_WORD/AXI_RESP_OKAY constants shared with the I-side bridge; no sub-module.
// TESTING
// Fill @0x0000_0040, ARREADY immediate, 4 RVALID back-to-back 0xA0..0xA3 -> ARLEN=3, D_wait low 4 consecutive cycles with D_out A0,A1,A2,A3, then DONE.
// Uncached read @0x1000_0008, RVALID delayed 5 cycles -> ARLEN=0, single D_wait-low, D_out=RDATA, no second AR while request held in DONE.
// Write @0x0000_0106 D_strb=4'b0011 D_in=0xDEADBEEF, WREADY 3 cycles before AWREADY -> AWADDR=0x104, WSTRB=4'b1100, one D_wait-low after B.
// Fill with RVALID gaps and RRESP=SLVERR on beat 2 -> 4 beats still delivered, D_err=1 only with the 4th D_wait-low.
// rstn low during R beat 1 -> all outputs at reset values immediately; next request after release starts a fresh AR.

Source files
------------

// File: rtl/dcache_bus_pkg.sv
// Shared AXI bus definitions for the cache-side bridges: FSM state encoding,
// AXI constant fields and response classification.
package dcache_bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_AR,
    ST_R,
    ST_AWW,
    ST_B,
    ST_DONE
  } state_t;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_WORD  = 3'b010;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  function automatic logic resp_is_err(input logic [1:0] resp);
    return resp != AXI_RESP_OKAY;
  endfunction

endpackage

// File: rtl/dcache_axi_bridge.sv
// L1 D-cache memory port to AXI4 master: line fills, uncached word reads and
// single-beat word writes, returning one D_wait-low cycle per delivered beat.
module dcache_axi_bridge
  import dcache_bus_pkg::*;
#(
  parameter logic [15:0] UNCACHE_HI = 16'h1000,
  parameter int          LINE_BEATS = 4
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        D_req_read,
  input  logic [31:0] D_addr,
  input  logic [31:0] D_in,
  input  logic [3:0]  D_strb,
  output logic [31:0] D_out,
  output logic        D_wait,
  output logic        D_err,
  output logic [31:0] ARADDR,
  output logic [3:0]  ARLEN,
  output logic        ARVALID,
  input  logic        ARREADY,
  input  logic [31:0] RDATA,
  input  logic [1:0]  RRESP,
  input  logic        RVALID,
  output logic        RREADY,
  output logic [31:0] AWADDR,
  output logic        AWVALID,
  input  logic        AWREADY,
  output logic [31:0] WDATA,
  output logic [3:0]  WSTRB,
  output logic        WVALID,
  input  logic        WREADY,
  input  logic [1:0]  BRESP,
  input  logic        BVALID,
  output logic        BREADY
);

  localparam logic [3:0] FILL_LEN = 4'(LINE_BEATS - 1);

  state_t      state_reg, state_next;
  logic [3:0]  beat_cnt_reg;
  logic [3:0]  arlen_reg;
  logic [3:0]  wstrb_reg;
  logic [31:0] addr_reg;
  logic [31:0] wdata_reg;
  logic [31:0] d_out_reg;
  logic        d_wait_reg;
  logic        d_err_reg;
  logic        err_reg;
  logic        aw_done_reg;
  logic        w_done_reg;

  logic write_req;
  logic accept;
  logic r_hs, aw_hs, w_hs, b_hs;
  logic last_beat;

  assign write_req = (D_strb != 4'hF);
  assign accept    = write_req || D_req_read;
  assign r_hs      = RVALID && RREADY;
  assign aw_hs     = AWVALID && AWREADY;
  assign w_hs      = WVALID && WREADY;
  assign b_hs      = BVALID && BREADY;
  assign last_beat = (beat_cnt_reg == arlen_reg);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        // A write wins when the cache presents both request kinds at once.
        if (write_req) begin
          state_next = ST_AWW;
        end else if (D_req_read) begin
          state_next = ST_AR;
        end
      end
      ST_AR:   if (ARREADY) state_next = ST_R;
      ST_R:    if (r_hs && last_beat) state_next = ST_DONE;
      ST_AWW:  if ((aw_done_reg || aw_hs) && (w_done_reg || w_hs)) state_next = ST_B;
      ST_B:    if (BVALID) state_next = ST_DONE;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    ARVALID = (state_reg == ST_AR);
    RREADY  = (state_reg == ST_R);
    AWVALID = (state_reg == ST_AWW) && !aw_done_reg;
    WVALID  = (state_reg == ST_AWW) && !w_done_reg;
    BREADY  = (state_reg == ST_B);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      beat_cnt_reg <= '0;
      arlen_reg    <= '0;
      wstrb_reg    <= '0;
      addr_reg     <= '0;
      wdata_reg    <= '0;
      d_out_reg    <= '0;
      d_wait_reg   <= 1'b1;
      d_err_reg    <= 1'b0;
      err_reg      <= 1'b0;
      aw_done_reg  <= 1'b0;
      w_done_reg   <= 1'b0;
    end else begin
      d_wait_reg <= 1'b1;
      d_err_reg  <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (accept) begin
            addr_reg     <= D_addr;
            wdata_reg    <= D_in;
            wstrb_reg    <= ~D_strb;
            arlen_reg    <= (D_addr[31:16] == UNCACHE_HI) ? 4'd0 : FILL_LEN;
            beat_cnt_reg <= '0;
            err_reg      <= 1'b0;
            aw_done_reg  <= 1'b0;
            w_done_reg   <= 1'b0;
          end
        end
        ST_R: begin
          if (r_hs) begin
            d_out_reg    <= RDATA;
            d_wait_reg   <= 1'b0;
            beat_cnt_reg <= beat_cnt_reg + 4'd1;
            err_reg      <= err_reg | resp_is_err(RRESP);
            d_err_reg    <= last_beat && (err_reg || resp_is_err(RRESP));
          end
        end
        ST_AWW: begin
          if (aw_hs) aw_done_reg <= 1'b1;
          if (w_hs)  w_done_reg  <= 1'b1;
        end
        ST_B: begin
          if (b_hs) begin
            d_wait_reg <= 1'b0;
            d_err_reg  <= err_reg || resp_is_err(BRESP);
          end
        end
        ST_DONE: begin
          beat_cnt_reg <= '0;
          err_reg      <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign D_out  = d_out_reg;
  assign D_wait = d_wait_reg;
  assign D_err  = d_err_reg;
  assign ARADDR = addr_reg;
  assign ARLEN  = arlen_reg;
  assign AWADDR = {addr_reg[31:2], 2'b00};
  assign WDATA  = wdata_reg;
  assign WSTRB  = wstrb_reg;

endmodule

// File: tb/tb_dcache_axi_bridge.sv
// Randomized bench for dcache_axi_bridge: a queue of expected D-port beats,
// built from the request and responses alone, is checked every cycle.
module tb_dcache_axi_bridge;

  localparam int LINE_BEATS = 4;

  typedef struct {
    logic [31:0] data;
    logic        err;
  } beat_t;

  logic        clk = 1'b0;
  logic        rstn;
  logic        D_req_read;
  logic [31:0] D_addr;
  logic [31:0] D_in;
  logic [3:0]  D_strb;
  logic [31:0] D_out;
  logic        D_wait;
  logic        D_err;
  logic [31:0] ARADDR;
  logic [3:0]  ARLEN;
  logic        ARVALID;
  logic        ARREADY;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RVALID;
  logic        RREADY;
  logic [31:0] AWADDR;
  logic        AWVALID;
  logic        AWREADY;
  logic [31:0] WDATA;
  logic [3:0]  WSTRB;
  logic        WVALID;
  logic        WREADY;
  logic [1:0]  BRESP;
  logic        BVALID;
  logic        BREADY;

  dcache_axi_bridge #(.UNCACHE_HI(16'h1000), .LINE_BEATS(LINE_BEATS)) dut (
    .clk(clk), .rstn(rstn),
    .D_req_read(D_req_read), .D_addr(D_addr), .D_in(D_in), .D_strb(D_strb),
    .D_out(D_out), .D_wait(D_wait), .D_err(D_err),
    .ARADDR(ARADDR), .ARLEN(ARLEN), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ar_hs_cnt = 0;
  int txn = 0;

  beat_t       exp_q[$];
  beat_t       cmp_e;
  logic [31:0] obs_data[$];
  logic        obs_err[$];
  int          obs_cyc[$];
  logic [31:0] last_rd = '0;
  logic [31:0] exp_araddr = '0;
  logic [3:0]  exp_arlen = '0;
  logic [31:0] exp_awaddr = '0;
  logic [31:0] exp_wdata = '0;
  logic [3:0]  exp_wstrb = '0;
  bit          ar_window = 0;
  bit          aw_window = 0;
  bit          w_window = 0;
  logic [3:0]  last_arlen = '0;
  logic [31:0] last_awaddr = '0;
  logic [31:0] last_wdata = '0;
  logic [3:0]  last_wstrb = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic finish_sim();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: handshake never completed, got timeout required completion", name);
    finish_sim();
  endtask

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rstn && ARVALID && ARREADY) ar_hs_cnt <= ar_hs_cnt + 1;
  end

  // Single compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    if (rstn) begin
      if (!D_wait) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got D_wait=0 D_out=%h required D_wait=1", D_out);
        end else begin
          cmp_e = exp_q.pop_front();
          check("d_out", D_out, cmp_e.data);
          check("d_err", 32'(D_err), 32'(cmp_e.err));
          obs_data.push_back(D_out);
          obs_err.push_back(D_err);
          obs_cyc.push_back(cyc);
        end
      end else begin
        check("d_err_while_wait", 32'(D_err), 32'd0);
      end
      if (!ar_window) check("arvalid_outside_read", 32'(ARVALID), 32'd0);
      if (!aw_window) check("awvalid_outside_write", 32'(AWVALID), 32'd0);
      if (!w_window)  check("wvalid_outside_write", 32'(WVALID), 32'd0);
      if (ARVALID) begin
        check("araddr", ARADDR, exp_araddr);
        check("arlen", 32'(ARLEN), 32'(exp_arlen));
        last_arlen = ARLEN;
      end
      if (AWVALID) begin
        check("awaddr", AWADDR, exp_awaddr);
        last_awaddr = AWADDR;
      end
      if (WVALID) begin
        check("wdata", WDATA, exp_wdata);
        check("wstrb", 32'(WSTRB), 32'(exp_wstrb));
        last_wdata = WDATA;
        last_wstrb = WSTRB;
      end
    end
  end

  // Negative delay/gap arguments mean "pick at random".
  task automatic do_read(input logic [31:0] addr, input int ar_dly, input int first_gap,
                         input int gap, input int err_beat, input bit directed);
    logic [31:0] dat[16];
    logic [1:0]  rsp[16];
    int          nb, dly, g, beat, cnt, bound;
    bit          uc, any_err, hs;
    beat_t       e;
    uc = (addr[31:16] == 16'h1000);
    nb = uc ? 1 : LINE_BEATS;
    any_err = 0;
    for (int i = 0; i < nb; i++) begin
      dat[i] = directed ? (32'hA0 + 32'(i)) : $urandom;
      if (err_beat == -2) rsp[i] = ($urandom_range(0, 5) == 0) ? 2'b10 : 2'b00;
      else rsp[i] = (i == err_beat) ? 2'b10 : 2'b00;
      if (rsp[i] != 2'b00) any_err = 1;
    end
    for (int i = 0; i < nb; i++) begin
      e.data = dat[i];
      e.err  = (i == nb - 1) && any_err;
      exp_q.push_back(e);
    end
    last_rd    = dat[nb-1];
    exp_araddr = addr;
    exp_arlen  = uc ? 4'd0 : 4'(LINE_BEATS - 1);
    ar_window  = 1;
    dly = (ar_dly < 0) ? int'($urandom_range(0, 3)) : ar_dly;
    @(posedge clk); #1;
    D_req_read = 1'b1;
    D_addr     = addr;
    D_strb     = 4'hF;
    D_in       = $urandom;
    cnt = 0; bound = 0; hs = 0;
    while (!hs) begin
      @(negedge clk);
      if (ARVALID && cnt >= dly) begin
        ARREADY = 1'b1;
        hs = 1;
      end else begin
        ARREADY = 1'b0;
        if (ARVALID) cnt++;
      end
      bound++;
      if (bound > 200) timeout_fail("ar_handshake");
    end
    @(posedge clk); #1;
    ARREADY   = 1'b0;
    ar_window = 0;
    beat = 0; bound = 0;
    g = (first_gap < 0) ? int'($urandom_range(0, 3)) : first_gap;
    while (beat < nb) begin
      @(negedge clk);
      if (g > 0) begin
        RVALID = 1'b0;
        g--;
      end else begin
        RVALID = 1'b1;
        RDATA  = dat[beat];
        RRESP  = rsp[beat];
        if (RREADY) begin
          beat++;
          g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
        end
      end
      bound++;
      if (bound > 400) timeout_fail("r_beats");
    end
    @(posedge clk); #1;
    RVALID = 1'b0;
    @(posedge clk); #1;
    check("read_beats_all_delivered", 32'(exp_q.size()), 32'd0);
    D_req_read = 1'b0;
    txn++;
    $display("txn %0d: read  addr=%h beats=%0d err=%0d", txn, addr, nb, any_err);
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [3:0] strb, input logic [31:0] din,
                          input int aw_dly, input int w_dly, input int b_dly,
                          input logic [1:0] bresp, input bit also_read);
    int    adly, wdly, bd, ac, wc, bound;
    bit    awd, wd, hs;
    beat_t e;
    e.data = last_rd;
    e.err  = (bresp != 2'b00);
    exp_q.push_back(e);
    exp_awaddr = {addr[31:2], 2'b00};
    exp_wdata  = din;
    exp_wstrb  = ~strb;
    aw_window  = 1;
    w_window   = 1;
    adly = (aw_dly < 0) ? int'($urandom_range(0, 3)) : aw_dly;
    wdly = (w_dly < 0) ? int'($urandom_range(0, 3)) : w_dly;
    bd   = (b_dly < 0) ? int'($urandom_range(0, 3)) : b_dly;
    @(posedge clk); #1;
    D_req_read = also_read;
    D_addr     = addr;
    D_strb     = strb;
    D_in       = din;
    ac = 0; wc = 0; awd = 0; wd = 0; bound = 0;
    while (!(awd && wd)) begin
      @(negedge clk);
      if (!awd && AWVALID && ac >= adly) begin
        AWREADY = 1'b1;
        awd = 1;
      end else begin
        AWREADY = 1'b0;
        if (AWVALID) ac++;
      end
      if (!wd && WVALID && wc >= wdly) begin
        WREADY = 1'b1;
        wd = 1;
      end else begin
        WREADY = 1'b0;
        if (WVALID) wc++;
      end
      bound++;
      if (bound > 200) timeout_fail("aw_w_handshake");
    end
    @(posedge clk); #1;
    AWREADY = 1'b0;
    WREADY  = 1'b0;
    aw_window = 0;
    w_window  = 0;
    hs = 0; bound = 0;
    while (!hs) begin
      @(negedge clk);
      if (bd > 0) begin
        BVALID = 1'b0;
        bd--;
      end else begin
        BVALID = 1'b1;
        BRESP  = bresp;
        if (BREADY) hs = 1;
      end
      bound++;
      if (bound > 200) timeout_fail("b_handshake");
    end
    @(posedge clk); #1;
    BVALID = 1'b0;
    @(posedge clk); #1;
    check("write_completion_delivered", 32'(exp_q.size()), 32'd0);
    D_req_read = 1'b0;
    D_strb     = 4'hF;
    txn++;
    $display("txn %0d: write addr=%h strb=%b data=%h bresp=%0d", txn, addr, strb, din, bresp);
  endtask

  task automatic clear_obs();
    obs_data.delete();
    obs_err.delete();
    obs_cyc.delete();
  endtask

  initial begin
    int          h0, bound;
    logic [31:0] a;
    logic [3:0]  s;
    rstn = 1'b0;
    D_req_read = 1'b0; D_addr = '0; D_in = '0; D_strb = 4'hF;
    ARREADY = 1'b0; RDATA = '0; RRESP = '0; RVALID = 1'b0;
    AWREADY = 1'b0; WREADY = 1'b0; BRESP = '0; BVALID = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_d_wait", 32'(D_wait), 32'd1);
    check("reset_d_out", D_out, 32'd0);
    check("reset_d_err", 32'(D_err), 32'd0);
    check("reset_valids", 32'({ARVALID, RREADY, AWVALID, WVALID, BREADY}), 32'd0);
    @(negedge clk);
    rstn = 1'b1;

    // Line fill, everything immediate: four consecutive beats A0..A3.
    clear_obs();
    do_read(32'h0000_0040, 0, 0, 0, -1, 1);
    check("fill_arlen", 32'(last_arlen), 32'd3);
    check("fill_nbeats", 32'(obs_data.size()), 32'd4);
    for (int i = 0; i < 4 && i < obs_data.size(); i++)
      check("fill_data_literal", obs_data[i], 32'hA0 + 32'(i));
    for (int i = 1; i < obs_cyc.size(); i++)
      check("fill_beats_consecutive", 32'(obs_cyc[i] - obs_cyc[i-1]), 32'd1);

    // Uncached read, RVALID 5 cycles late; request held through DONE.
    clear_obs();
    h0 = ar_hs_cnt;
    do_read(32'h1000_0008, 0, 5, 0, -1, 0);
    check("uncached_arlen", 32'(last_arlen), 32'd0);
    check("uncached_nbeats", 32'(obs_data.size()), 32'd1);
    check("uncached_single_ar", 32'(ar_hs_cnt - h0), 32'd1);

    // Write, WREADY three cycles ahead of AWREADY.
    clear_obs();
    do_write(32'h0000_0106, 4'b0011, 32'hDEADBEEF, 3, 0, 1, 2'b00, 0);
    check("write_awaddr", last_awaddr, 32'h0000_0104);
    check("write_wstrb", 32'(last_wstrb), 32'hC);
    check("write_wdata", last_wdata, 32'hDEADBEEF);
    check("write_nbeats", 32'(obs_data.size()), 32'd1);

    // Fill with gaps, SLVERR on beat 2: error reported only with the last beat.
    clear_obs();
    do_read(32'h0000_0080, 1, 2, 1, 2, 0);
    check("err_nbeats", 32'(obs_err.size()), 32'd4);
    for (int i = 0; i < 4 && i < obs_err.size(); i++)
      check("err_only_last", 32'(obs_err[i]), (i == 3) ? 32'd1 : 32'd0);

    // Reset while the first fill beat is being delivered.
    exp_araddr = 32'h0000_00C0;
    exp_arlen  = 4'(LINE_BEATS - 1);
    ar_window  = 1;
    @(posedge clk); #1;
    D_req_read = 1'b1; D_addr = 32'h0000_00C0; D_strb = 4'hF;
    bound = 0;
    while (!ARREADY) begin
      @(negedge clk);
      if (ARVALID) ARREADY = 1'b1;
      bound++;
      if (bound > 50) timeout_fail("reset_test_ar");
    end
    @(posedge clk); #1;
    ARREADY = 1'b0;
    ar_window = 0;
    @(negedge clk);
    RVALID = 1'b1; RDATA = 32'h5555_0001; RRESP = 2'b00;
    @(posedge clk); #2;
    rstn = 1'b0;
    #1;
    check("midreset_d_wait", 32'(D_wait), 32'd1);
    check("midreset_d_out", D_out, 32'd0);
    check("midreset_d_err", 32'(D_err), 32'd0);
    check("midreset_valids", 32'({ARVALID, RREADY, AWVALID, WVALID, BREADY}), 32'd0);
    RVALID = 1'b0;
    D_req_read = 1'b0;
    last_rd = '0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    clear_obs();
    h0 = ar_hs_cnt;
    do_read(32'h0000_0200, -1, -1, -1, -1, 0);
    check("postreset_fresh_ar", 32'(ar_hs_cnt - h0), 32'd1);
    check("postreset_nbeats", 32'(obs_data.size()), 32'(LINE_BEATS));

    // Randomized mix of fills, uncached reads and writes.
    for (int t = 0; t < 60; t++) begin
      case ($urandom_range(0, 2))
        0: begin
          a = $urandom & ~32'(LINE_BEATS * 4 - 1);
          if (a[31:16] == 16'h1000) a[31] = 1'b1;
          do_read(a, -1, -1, -1, -2, 0);
        end
        1: begin
          a = {16'h1000, 16'($urandom) & 16'hFFFC};
          do_read(a, -1, -1, -1, -2, 0);
        end
        default: begin
          a = $urandom;
          s = 4'($urandom_range(0, 14));
          do_write(a, s, $urandom, -1, -1, -1,
                   ($urandom_range(0, 3) == 0) ? 2'b10 : 2'b00, 1'($urandom_range(0, 1)));
        end
      endcase
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end
    repeat (3) @(posedge clk);
    finish_sim();
  end

  initial begin
    #5_000_000;
    checks++;
    errors++;
    $display("FAIL watchdog: got simulation still running required completion");
    finish_sim();
  end

endmodule
